// File: rtl/clause_ctrl_pkg.sv
// Shared types and derived widths for the clause load/readback controller.
package clause_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RD,
    CAP,
    OUT
  } state_t;

  // One extra bit so a count of NUM_CLAUSES itself is representable.
  function automatic int idx_width(input int num_clauses);
    return $clog2(num_clauses) + 1;
  endfunction

endpackage

// File: rtl/clause_load_ctrl_idx_onehot.sv
// Slot index to one-hot strobe decoder; indices past the last slot decode to zero.
module idx_onehot #(
  parameter int WIDTH_IDX   = 4,
  parameter int NUM_CLAUSES = 8
) (
  input  logic [WIDTH_IDX-1:0]   idx,
  output logic [NUM_CLAUSES-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int k = 0; k < NUM_CLAUSES; k++) begin
      onehot[k] = (idx == WIDTH_IDX'(k));
    end
  end

endmodule

// File: rtl/clause_load_ctrl.sv
// Loads host clauses into the clause array slot by slot and reads every slot
// back through a valid/ready stream.
module clause_load_ctrl
  import clause_ctrl_pkg::*;
#(
  parameter int NUM_CLAUSES = 8,
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_C_LEN = 4,
  parameter int WIDTH_IDX   = idx_width(NUM_CLAUSES)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load_start_i,
  input  logic [WIDTH_IDX-1:0]               load_num_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [NUM_VARS*2-1:0]              in_clause_i,
  input  logic [WIDTH_C_LEN-1:0]             in_len_i,
  input  logic                               dump_start_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [NUM_VARS*2-1:0]              out_clause_o,
  output logic [WIDTH_C_LEN-1:0]             out_len_o,
  output logic [WIDTH_IDX-1:0]               out_idx_o,
  output logic [NUM_CLAUSES-1:0]             wr_o,
  output logic [NUM_CLAUSES-1:0]             rd_o,
  output logic [NUM_VARS*2-1:0]              clause_o,
  output logic [WIDTH_C_LEN-1:0]             clause_len_o,
  input  logic [NUM_VARS*2-1:0]              clause_i,
  input  logic [WIDTH_C_LEN*NUM_CLAUSES-1:0] clause_len_i,
  output logic                               busy_o,
  output logic                               done_o
);

  localparam logic [WIDTH_IDX-1:0] MAX_NUM   = WIDTH_IDX'(NUM_CLAUSES);
  localparam logic [WIDTH_IDX-1:0] LAST_SLOT = WIDTH_IDX'(NUM_CLAUSES - 1);

  state_t                 state, state_next;
  logic [WIDTH_IDX-1:0]   idx, idx_next;
  logic [WIDTH_IDX-1:0]   num, num_next;
  logic [WIDTH_IDX-1:0]   num_clamped;
  logic [NUM_CLAUSES-1:0] sel;
  logic [WIDTH_C_LEN-1:0] len_sel;
  logic                   accept, capture, pop, done_next;

  // One decoder serves both strobes; LOAD and RD never overlap.
  idx_onehot #(
    .WIDTH_IDX  (WIDTH_IDX),
    .NUM_CLAUSES(NUM_CLAUSES)
  ) u_idx_onehot (
    .idx   (idx),
    .onehot(sel)
  );

  assign num_clamped = (load_num_i > MAX_NUM) ? MAX_NUM : load_num_i;
  assign busy_o      = (state != IDLE);
  assign in_ready_o  = (state == LOAD);
  assign rd_o        = (state == RD) ? sel : '0;

  always_comb begin
    len_sel = '0;
    for (int k = 0; k < NUM_CLAUSES; k++) begin
      if (idx == WIDTH_IDX'(k)) len_sel = clause_len_i[k*WIDTH_C_LEN +: WIDTH_C_LEN];
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    num_next   = num;
    done_next  = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start_i) begin
          num_next = num_clamped;
          idx_next = '0;
          if (num_clamped == '0) done_next = 1'b1;
          else state_next = LOAD;
        end else if (dump_start_i) begin
          idx_next   = '0;
          state_next = RD;
        end
      end
      LOAD: begin
        if (in_valid_i) begin
          accept   = 1'b1;
          idx_next = idx + 1'b1;
          if (idx == num - 1'b1) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      RD: state_next = CAP;
      CAP: begin
        capture    = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        if (out_valid_o && out_ready_i) begin
          pop = 1'b1;
          if (idx == LAST_SLOT) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            idx_next   = idx + 1'b1;
            state_next = RD;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Array write port and readback register; write data holds between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx          <= '0;
      num          <= '0;
      done_o       <= 1'b0;
      wr_o         <= '0;
      clause_o     <= '0;
      clause_len_o <= '0;
      out_valid_o  <= 1'b0;
      out_clause_o <= '0;
      out_len_o    <= '0;
      out_idx_o    <= '0;
    end else begin
      idx    <= idx_next;
      num    <= num_next;
      done_o <= done_next;
      wr_o   <= accept ? sel : '0;
      if (accept) begin
        clause_o     <= in_clause_i;
        clause_len_o <= in_len_i;
      end
      if (capture) begin
        out_clause_o <= clause_i;
        out_len_o    <= len_sel;
        out_idx_o    <= idx;
        out_valid_o  <= 1'b1;
      end else if (pop) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clause_load_ctrl.sv
// Randomised scoreboard bench for clause_load_ctrl with a behavioural clause
// array attached to its write/read ports.
module tb_clause_load_ctrl;

  localparam int NC = 8;
  localparam int NV = 8;
  localparam int LW = 4;
  localparam int WI = $clog2(NC) + 1;
  localparam int CW = NV * 2;

  typedef struct {
    int            slot;
    logic [CW-1:0] clause;
    logic [LW-1:0] len;
    bit            last;
    int            cyc;
  } wr_item_t;

  typedef struct {
    int            slot;
    logic [CW-1:0] clause;
    logic [LW-1:0] len;
  } out_item_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_start_i = 1'b0;
  logic [WI-1:0] load_num_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [CW-1:0] in_clause_i = '0;
  logic [LW-1:0] in_len_i = '0;
  logic          dump_start_i = 1'b0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [CW-1:0] out_clause_o;
  logic [LW-1:0] out_len_o;
  logic [WI-1:0] out_idx_o;
  logic [NC-1:0] wr_o, rd_o;
  logic [CW-1:0] clause_o;
  logic [LW-1:0] clause_len_o;
  logic [CW-1:0] clause_i;
  logic [LW*NC-1:0] clause_len_i;
  logic          busy_o, done_o;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit zero_done_due = 0;
  bit dump_done_due = 0;

  wr_item_t  exp_wr[$];
  out_item_t exp_out[$];
  int        exp_rd[$];
  logic [CW-1:0] ref_mem [NC];
  logic [LW-1:0] ref_len [NC];

  logic [CW-1:0] mem [NC];
  logic [LW-1:0] mem_len [NC];
  logic [NC-1:0] rd_q;

  clause_load_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .load_start_i(load_start_i),
    .load_num_i  (load_num_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_clause_i (in_clause_i),
    .in_len_i    (in_len_i),
    .dump_start_i(dump_start_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_clause_o(out_clause_o),
    .out_len_o   (out_len_o),
    .out_idx_o   (out_idx_o),
    .wr_o        (wr_o),
    .rd_o        (rd_o),
    .clause_o    (clause_o),
    .clause_len_o(clause_len_o),
    .clause_i    (clause_i),
    .clause_len_i(clause_len_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Clause array: registered OR-combined read, lengths always visible.
  always @(posedge clk) begin
    for (int k = 0; k < NC; k++) begin
      if (wr_o[k]) begin
        mem[k]     <= clause_o;
        mem_len[k] <= clause_len_o;
      end
    end
    rd_q <= rd_o;
  end

  always_comb begin
    clause_i     = '0;
    clause_len_i = '0;
    for (int k = 0; k < NC; k++) begin
      if (rd_q[k]) clause_i = clause_i | mem[k];
      clause_len_i[k*LW +: LW] = mem_len[k];
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe or output.
  initial begin : monitor
    wr_item_t  w;
    out_item_t o;
    int        s;
    bit        exp_done;
    forever begin
      @(negedge clk);
      exp_done      = dump_done_due | zero_done_due;
      dump_done_due = 0;
      zero_done_due = 0;
      if (wr_o != '0) begin
        if (exp_wr.size() == 0) begin
          check_output("unexpected_wr", wr_o, 0);
        end else begin
          w = exp_wr.pop_front();
          check_output("wr_strobe", wr_o, 64'(1) << w.slot);
          check_output("wr_clause", clause_o, w.clause);
          check_output("wr_len", clause_len_o, w.len);
          check_output("wr_cycle", cyc, w.cyc);
          exp_done = exp_done | w.last;
        end
      end
      if (rd_o != '0) begin
        check_output("wr_rd_exclusive", wr_o, 0);
        if (exp_rd.size() == 0) begin
          check_output("unexpected_rd", rd_o, 0);
        end else begin
          s = exp_rd.pop_front();
          check_output("rd_strobe", rd_o, 64'(1) << s);
        end
      end
      if (out_valid_o) begin
        if (exp_out.size() == 0) begin
          check_output("unexpected_out", out_valid_o, 0);
        end else begin
          o = exp_out[0];
          check_output("out_idx", out_idx_o, o.slot);
          check_output("out_clause", out_clause_o, o.clause);
          check_output("out_len", out_len_o, o.len);
          if (out_ready_i) begin
            void'(exp_out.pop_front());
            if (o.slot == NC - 1) dump_done_due = 1;
          end
        end
      end
      check_output("done_pulse", done_o, exp_done);
    end
  end

  task automatic apply_load(input int num_req, input bit gaps, input bit directed,
                            input bit both_start, input int abort_after);
    int            n;
    int            gap;
    bit            aborted;
    logic [CW-1:0] c;
    logic [LW-1:0] l;
    wr_item_t      w;
    n       = (num_req > NC) ? NC : num_req;
    aborted = 0;
    load_num_i   = WI'(num_req);
    load_start_i = 1'b1;
    dump_start_i = both_start;
    @(posedge clk); #1;
    load_start_i = 1'b0;
    dump_start_i = 1'b0;
    if (n == 0) begin
      zero_done_due = 1;
    end else begin
      check_output("in_ready_in_load", in_ready_o, 1);
      for (int i = 0; i < n; i++) begin
        if (abort_after == i) begin
          aborted = 1;
          break;
        end
        gap = gaps ? $urandom_range(0, 2) : 0;
        if (gap > 0) begin
          in_valid_i = 1'b0;
          repeat (gap) begin @(posedge clk); #1; end
        end
        c = directed ? (CW'(1) << (2 * i)) : CW'($urandom);
        l = directed ? LW'(1) : LW'($urandom);
        in_valid_i   = 1'b1;
        in_clause_i  = c;
        in_len_i     = l;
        dump_start_i = both_start && (i == 1);
        @(posedge clk); #1;
        dump_start_i = 1'b0;
        w = '{slot: i, clause: c, len: l, last: (i == n - 1), cyc: cyc};
        exp_wr.push_back(w);
        ref_mem[i] = c;
        ref_len[i] = l;
      end
      in_valid_i = 1'b0;
    end
    if (aborted) begin
      @(negedge clk); #1;
      rst = 1'b0;
      #1;
      check_output("reset_outputs",
                   {wr_o, rd_o, clause_o, clause_len_o, out_valid_o, out_clause_o,
                    out_len_o, out_idx_o, in_ready_o, busy_o, done_o}, 0);
      @(posedge clk); #1;
      rst = 1'b1;
    end
    repeat (3) begin @(posedge clk); #1; end
    check_output("load_drained", exp_wr.size(), 0);
    check_output("idle_after_load", {busy_o, in_ready_o}, 0);
  endtask

  task automatic apply_dump(input int stall_slot, input int stall_len);
    int t;
    int stall;
    for (int s = 0; s < NC; s++) begin
      exp_rd.push_back(s);
      exp_out.push_back('{slot: s, clause: ref_mem[s], len: ref_len[s]});
    end
    dump_start_i = 1'b1;
    @(posedge clk); #1;
    dump_start_i = 1'b0;
    for (int s = 0; s < NC; s++) begin
      t = 0;
      while (!out_valid_o && t < 20) begin @(posedge clk); #1; t++; end
      if (!out_valid_o) begin
        check_output("out_valid_timeout", out_valid_o, 1);
        break;
      end
      stall = (s == stall_slot) ? stall_len : $urandom_range(0, 2);
      repeat (stall) begin @(posedge clk); #1; end
      out_ready_i = 1'b1;
      @(posedge clk); #1;
      out_ready_i = 1'b0;
    end
    repeat (3) begin @(posedge clk); #1; end
    check_output("dump_out_drained", exp_out.size(), 0);
    check_output("dump_rd_drained", exp_rd.size(), 0);
    check_output("idle_after_dump", busy_o, 0);
    exp_out.delete();
    exp_rd.delete();
  endtask

  initial begin : stimulus
    repeat (3) begin @(posedge clk); #1; end
    check_output("reset_outputs",
                 {wr_o, rd_o, clause_o, clause_len_o, out_valid_o, out_clause_o,
                  out_len_o, out_idx_o, in_ready_o, busy_o, done_o}, 0);
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    $display("[TB] three directed clauses, valid held high");
    apply_load(3, 0, 1, 0, -1);
    $display("[TB] oversize request clamps to full array");
    apply_load(12, 1, 0, 0, -1);
    $display("[TB] readback with slot 2 stalled");
    apply_dump(2, 5);
    $display("[TB] simultaneous starts, dump ignored during load");
    apply_load(5, 0, 0, 1, -1);
    $display("[TB] reset mid-load then normal load");
    apply_load(4, 0, 0, 0, 2);
    apply_load(4, 1, 0, 0, -1);
    $display("[TB] zero-length load");
    apply_load(0, 0, 0, 0, -1);
    apply_dump(-1, 0);

    for (int r = 0; r < 6; r++) begin
      apply_load($urandom_range(1, 12), 1, 0, 0, -1);
      apply_dump($urandom_range(0, NC - 1), $urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clause_load_ctrl.md
CLAUSE_LOAD_CTRL -- requirements
Module: clause_load_ctrl

Interface
REQ-001 Parameters SHALL be: NUM_CLAUSES, default 8, number of clause slots in the array; NUM_VARS, default 8, variables per clause (2 bits each); WIDTH_C_LEN, default 4, clause-length width; WIDTH_IDX = $clog2(NUM_CLAUSES)+1 (derived).
REQ-002 The design SHALL use one clock and an asynchronous, active-low reset; ports are named clk and rst.
REQ-003 The ports SHALL be:
- clk  in  1  clock
- rst  in  1  async active-low reset
- load_start_i  in  1  start-load pulse
- load_num_i  in  WIDTH_IDX  clauses to load
- in_valid_i  in  1  host clause valid
- in_ready_o  out  1  host clause accepted
- in_clause_i  in  NUM_VARS*2  host clause bits
- in_len_i  in  WIDTH_C_LEN  host clause length
- dump_start_i  in  1  start-readback pulse
- out_valid_o  out  1  readback valid
- out_ready_i  in  1  readback consumed
- out_clause_o  out  NUM_VARS*2  readback clause
- out_len_o  out  WIDTH_C_LEN  readback length
- out_idx_o  out  WIDTH_IDX  readback slot index
- wr_o  out  NUM_CLAUSES  one-hot array write strobe
- rd_o  out  NUM_CLAUSES  one-hot array read strobe
- clause_o  out  NUM_VARS*2  write data to array
- clause_len_o  out  WIDTH_C_LEN  write length to array
- clause_i  in  NUM_VARS*2  OR-combined array read data
- clause_len_i  in  WIDTH_C_LEN*NUM_CLAUSES  all slot lengths, slot k at bits [k*WIDTH_C_LEN +: WIDTH_C_LEN]
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse

Function
REQ-004 The FSM SHALL have the states IDLE, LOAD, RD, CAP and OUT; busy_o = (state != IDLE).
REQ-005 In IDLE, load_start_i SHALL latch num = min(load_num_i, NUM_CLAUSES), clear idx and enter LOAD; if num = 0, the block SHALL stay in IDLE and pulse done_o next cycle.
REQ-006 In IDLE, dump_start_i SHALL clear idx and enter RD; if both start inputs are high in the same cycle, load SHALL win.
REQ-007 Start pulses received while not in IDLE SHALL be ignored.
REQ-008 In LOAD, in_ready_o SHALL be 1; a handshake (in_valid_i & in_ready_o) in cycle t SHALL produce, in cycle t+1, wr_o = onehot(idx), clause_o = in_clause_i and clause_len_o = in_len_i, all registered; idx then increments.
REQ-009 wr_o SHALL be high for exactly one cycle per accepted clause; clause_o and clause_len_o SHALL hold their values otherwise.
REQ-010 On the handshake with idx = num-1, the block SHALL return to IDLE and pulse done_o in the same cycle as the final wr_o.
REQ-011 In RD, rd_o SHALL be onehot(idx) for one cycle, then the block enters CAP; the array returns data one cycle after rd_o.
REQ-012 In CAP, the block SHALL register out_clause_o = clause_i, out_len_o = clause_len_i slice idx and out_idx_o = idx, set out_valid_o, and enter OUT.
REQ-013 In OUT, the outputs SHALL hold until out_valid_o & out_ready_i; then out_valid_o clears and:
- if idx = NUM_CLAUSES-1: IDLE, with done_o pulsed.
- otherwise: idx+1 and return to RD.
REQ-014 The following SHALL be 0 in every cycle in which they are not explicitly driven: wr_o, rd_o, in_ready_o (outside LOAD), done_o.
REQ-015 wr_o and rd_o SHALL never be non-zero in the same cycle.

Reset
REQ-016 On rst low, the block SHALL asynchronously enter IDLE and force to zero: wr_o, rd_o, clause_o, clause_len_o, out_valid_o, out_clause_o, out_len_o, out_idx_o, in_ready_o, busy_o, done_o, idx and num.
REQ-017 A reset asserted mid-operation SHALL abandon the operation without a done_o pulse; partially loaded slots keep their contents in the array.

Structure
REQ-018 The state enum and the WIDTH_IDX computation SHALL live in a shared package, clause_ctrl_pkg.
REQ-019 The one-hot index decoder SHALL be a single sub-module, idx_onehot (WIDTH_IDX in, NUM_CLAUSES out), instantiated once and shared by wr_o and rd_o.

Verification
REQ-020 Load 3 clauses (0x0001, 0x0004, 0x0010; len 1, 1, 1), in_valid held high -> wr_o = 01, 02, 04 on consecutive cycles; done_o coincides with wr_o = 04.
REQ-021 load_num_i = 12 with NUM_CLAUSES = 8 -> exactly 8 writes, wr_o bit 7 last, then IDLE.
REQ-022 Dump after load with out_ready_i = 0 for 5 cycles on slot 2 -> out_clause_o stable throughout; out_idx_o sequence 0..7; rd_o pulses once per slot.
REQ-023 load_start_i and dump_start_i in the same cycle -> LOAD entered; dump_start_i during LOAD -> ignored.
REQ-024 rst low after the 2nd write of a 4-clause load -> next cycle all outputs are 0, done_o is never pulsed, and a subsequent load works normally.
REQ-025 load_num_i = 0 -> no wr_o activity and done_o pulses one cycle later.
